// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants, tx state encoding and frame packing helper for the CONV input path
package conv_pkg;

    localparam int CONV_DW    = 3;
    localparam int CONV_TAPS  = 4;
    localparam int CONV_OUT_W = 8;
    localparam int CONV_FRM_W = CONV_DW * CONV_TAPS;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_GAP
    } tx_state_t;

    // Element k lives at bits [k*CONV_DW +: CONV_DW]; element 0 goes out first.
    function automatic logic [CONV_FRM_W-1:0] conv_pack_elem(
        input logic [CONV_FRM_W-1:0] frame,
        input int unsigned           k,
        input logic [CONV_DW-1:0]    elem
    );
        logic [CONV_FRM_W-1:0] f;
        f = frame;
        f[k*CONV_DW +: CONV_DW] = elem;
        return f;
    endfunction

endpackage

// File: rtl/conv_frame_tx_if.sv
// rtl/conv_frame_tx_if.sv - frame handshake and burst bus between the upstream source and conv_frame_tx
interface conv_frame_tx_if import conv_pkg::*; #(
    parameter int DW   = CONV_DW,
    parameter int TAPS = CONV_TAPS
) ();

    logic                 frm_valid;
    logic                 frm_ready;
    logic [DW*TAPS-1:0]   frm_h;
    logic [DW*TAPS-1:0]   frm_x;
    logic                 in_valid;
    logic [DW-1:0]        in_data1;
    logic [DW-1:0]        in_data2;

    modport master (
        output frm_valid, frm_h, frm_x,
        input  frm_ready, in_valid, in_data1, in_data2
    );

    modport slave (
        input  frm_valid, frm_h, frm_x,
        output frm_ready, in_valid, in_data1, in_data2
    );

endinterface

// File: rtl/conv_frame_buf.sv
// rtl/conv_frame_buf.sv - one-entry holding register that queues the next frame while a burst is in flight
module conv_frame_buf #(
    parameter int W = 24
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_full
);

    logic         r_full;
    logic [W-1:0] r_data;

    // Push only happens while empty and pop only while full, so they never collide.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_push) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule

// File: rtl/conv_frame_tx.sv
// rtl/conv_frame_tx.sv - serialises parallel h/x frames into TAPS-beat bursts separated by a GAP-cycle idle gap
module conv_frame_tx import conv_pkg::*; #(
    parameter int DW   = CONV_DW,
    parameter int TAPS = CONV_TAPS,
    parameter int GAP  = 16
) (
    input  logic                  clk_1,
    input  logic                  rst_n,
    conv_frame_tx_if.slave        bus,
    output logic                  busy,
    output logic [CONV_OUT_W-1:0] frames_sent
);

    localparam int FRM_W  = DW * TAPS;
    localparam int BEAT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int GAP_W  = (GAP > 1) ? $clog2(GAP + 1) : 1;

    if (GAP < 1) begin : g_gap_check
        $fatal(1, "conv_frame_tx: GAP must be at least 1");
    end

    tx_state_t             r_state;
    logic [BEAT_W-1:0]     r_beat;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic [FRM_W-1:0]      r_sh_h;
    logic [FRM_W-1:0]      r_sh_x;
    logic                  r_in_valid;
    logic [DW-1:0]         r_in_data1;
    logic [DW-1:0]         r_in_data2;
    logic [CONV_OUT_W-1:0] r_frames_sent;

    logic                  w_buf_full;
    logic [2*FRM_W-1:0]    w_buf_data;
    logic                  w_accept;
    logic                  w_gap_end;
    logic                  w_last_beat;
    logic                  w_load_direct;
    logic                  w_push;
    logic                  w_pop;

    assign w_accept    = bus.frm_valid && !w_buf_full;
    assign w_gap_end   = (r_state == TX_GAP) && (r_gap_cnt == GAP_W'(GAP - 1));
    assign w_last_beat = (r_beat == BEAT_W'(TAPS - 1));
    // A frame arriving on the last gap edge with nothing buffered skips the buffer entirely.
    assign w_load_direct = w_accept && ((r_state == TX_IDLE) || (w_gap_end && !w_buf_full));
    assign w_push        = w_accept && !w_load_direct;
    assign w_pop         = w_gap_end && w_buf_full;

    conv_frame_buf #(
        .W (2 * FRM_W)
    ) u_buf (
        .i_clk   (clk_1),
        .i_rst_n (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({bus.frm_h, bus.frm_x}),
        .o_data  (w_buf_data),
        .o_full  (w_buf_full)
    );

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= TX_IDLE;
            r_beat        <= '0;
            r_gap_cnt     <= '0;
            r_sh_h        <= '0;
            r_sh_x        <= '0;
            r_in_valid    <= 1'b0;
            r_in_data1    <= '0;
            r_in_data2    <= '0;
            r_frames_sent <= '0;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    r_in_valid <= 1'b0;
                    r_in_data1 <= '0;
                    r_in_data2 <= '0;
                    if (w_load_direct) begin
                        r_sh_h  <= bus.frm_h;
                        r_sh_x  <= bus.frm_x;
                        r_beat  <= '0;
                        r_state <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    r_in_valid <= 1'b1;
                    r_in_data1 <= r_sh_h[DW-1:0];
                    r_in_data2 <= r_sh_x[DW-1:0];
                    r_sh_h     <= r_sh_h >> DW;
                    r_sh_x     <= r_sh_x >> DW;
                    if (w_last_beat) begin
                        r_state       <= TX_GAP;
                        r_gap_cnt     <= '0;
                        r_frames_sent <= r_frames_sent + 1'b1;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                TX_GAP: begin
                    r_in_valid <= 1'b0;
                    r_in_data1 <= '0;
                    r_in_data2 <= '0;
                    if (w_gap_end) begin
                        r_beat <= '0;
                        if (w_pop) begin
                            r_sh_h  <= w_buf_data[2*FRM_W-1:FRM_W];
                            r_sh_x  <= w_buf_data[FRM_W-1:0];
                            r_state <= TX_SEND;
                        end else if (w_load_direct) begin
                            r_sh_h  <= bus.frm_h;
                            r_sh_x  <= bus.frm_x;
                            r_state <= TX_SEND;
                        end else begin
                            r_state <= TX_IDLE;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign bus.frm_ready = !w_buf_full;
    assign bus.in_valid  = r_in_valid;
    assign bus.in_data1  = r_in_data1;
    assign bus.in_data2  = r_in_data2;
    assign busy          = (r_state != TX_IDLE) || w_buf_full;
    assign frames_sent   = r_frames_sent;

endmodule

// File: tb/tb_conv_frame_tx.sv
// tb/tb_conv_frame_tx.sv - scoreboard bench for conv_frame_tx: directed frames, timing, buffering, reset and wrap
module tb_conv_frame_tx;
    import conv_pkg::*;

    localparam int DW   = CONV_DW;
    localparam int TAPS = CONV_TAPS;
    localparam int GAP  = 16;
    localparam int FW   = DW * TAPS;

    typedef struct packed { logic [FW-1:0] h; logic [FW-1:0] x; } frame_t;
    typedef struct packed { logic [DW-1:0] h; logic [DW-1:0] x; } beat_t;

    logic       clk_1 = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic [7:0] frames_sent;

    conv_frame_tx_if #(.DW(DW), .TAPS(TAPS)) bus ();

    conv_frame_tx #(.DW(DW), .TAPS(TAPS), .GAP(GAP)) dut (
        .clk_1       (clk_1),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    always #5 clk_1 = ~clk_1;

    int cyc = 0;
    always @(posedge clk_1) cyc <= cyc + 1;

    int     n_cmp = 0;
    int     n_err = 0;
    int     exp_sent = 0;
    frame_t stim_q[$];
    beat_t  exp_q[$];
    int     acc_q[$];
    int     first_q[$];
    int     rise_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic frame_t mk(input int h0, h1, h2, h3, x0, x1, x2, x3);
        frame_t f;
        f.h = '0;
        f.x = '0;
        f.h = conv_pack_elem(f.h, 0, 3'(h0));
        f.h = conv_pack_elem(f.h, 1, 3'(h1));
        f.h = conv_pack_elem(f.h, 2, 3'(h2));
        f.h = conv_pack_elem(f.h, 3, 3'(h3));
        f.x = conv_pack_elem(f.x, 0, 3'(x0));
        f.x = conv_pack_elem(f.x, 1, 3'(x1));
        f.x = conv_pack_elem(f.x, 2, 3'(x2));
        f.x = conv_pack_elem(f.x, 3, 3'(x3));
        return f;
    endfunction

    // Driver: presents the head of stim_q; scrambles data whenever the DUT is not ready.
    initial begin
        bit     hs;
        frame_t f;
        beat_t  b;
        bus.frm_valid = 1'b0;
        bus.frm_h     = '0;
        bus.frm_x     = '0;
        forever begin
            @(negedge clk_1);
            hs = rst_n && bus.frm_valid && bus.frm_ready;
            @(posedge clk_1);
            #1;
            if (!rst_n) stim_q.delete();
            if (hs && stim_q.size() > 0) begin
                f = stim_q.pop_front();
                for (int k = 0; k < TAPS; k++) begin
                    b.h = f.h[k*DW +: DW];
                    b.x = f.x[k*DW +: DW];
                    exp_q.push_back(b);
                end
                acc_q.push_back(cyc);
            end
            if (rst_n && stim_q.size() > 0) begin
                bus.frm_valid = 1'b1;
                if (bus.frm_ready) begin
                    bus.frm_h = stim_q[0].h;
                    bus.frm_x = stim_q[0].x;
                end else begin
                    bus.frm_h = FW'($urandom);
                    bus.frm_x = FW'($urandom);
                end
            end else begin
                bus.frm_valid = 1'b0;
                bus.frm_h     = '0;
                bus.frm_x     = '0;
            end
        end
    end

    // Monitor: pops the scoreboard on every beat and checks burst shape and counter.
    bit prev_v = 1'b0;
    bit prev_ready = 1'b1;
    int run = 0;
    int last_beat_cyc = -1;
    always @(negedge clk_1) begin
        beat_t b;
        if (!rst_n) begin
            prev_v = 1'b0;
            run = 0;
            last_beat_cyc = -1;
            exp_sent = 0;
            exp_q.delete();
        end else begin
            if (bus.in_valid) begin
                if (!prev_v) begin
                    first_q.push_back(cyc);
                    if (last_beat_cyc >= 0)
                        check("gap_min", 32'((cyc - last_beat_cyc - 1) >= GAP), 1);
                end
                run++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got h=%0d x=%0d expected no beat (cycle %0d)",
                             bus.in_data1, bus.in_data2, cyc);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_h", 32'(bus.in_data1), 32'(b.h));
                    check("beat_x", 32'(bus.in_data2), 32'(b.x));
                end
                if (run == TAPS) begin
                    exp_sent++;
                    check("frames_sent", 32'(frames_sent), exp_sent % 256);
                end
                last_beat_cyc = cyc;
            end else begin
                if (prev_v) check("burst_len", run, TAPS);
                run = 0;
                check("idle_data", 32'({bus.in_data1, bus.in_data2}), 0);
            end
            prev_v = bus.in_valid;
        end
        if (rst_n && bus.frm_ready && !prev_ready) rise_q.push_back(cyc);
        prev_ready = bus.frm_ready;
    end

    task automatic wait_acc(input int n, input int budget);
        int t = 0;
        while (acc_q.size() < n && t < budget) begin @(posedge clk_1); #2; t++; end
        if (acc_q.size() < n) check("wait_accept_timeout", acc_q.size(), n);
    endtask

    task automatic wait_first(input int n, input int budget);
        int t = 0;
        while (first_q.size() < n && t < budget) begin @(posedge clk_1); #2; t++; end
        if (first_q.size() < n) check("wait_burst_timeout", first_q.size(), n);
    endtask

    task automatic wait_cyc(input int c);
        int t = 0;
        while (cyc < c && t < 1000) begin @(posedge clk_1); #2; t++; end
        if (cyc < c) check("wait_cycle_timeout", cyc, c);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0 || busy || bus.in_valid) && t < budget) begin
            @(posedge clk_1); #2; t++;
        end
        check("wait_idle_timeout", 32'(t < budget), 1);
    endtask

    initial begin
        int n, m, r, f, e;
        frame_t fr;

        repeat (3) @(posedge clk_1);
        #2;
        check("rst_in_valid", 32'(bus.in_valid), 0);
        check("rst_in_data", 32'({bus.in_data1, bus.in_data2}), 0);
        check("rst_frm_ready", 32'(bus.frm_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_frames_sent", 32'(frames_sent), 0);
        rst_n = 1'b1;

        // 1: single frame, latency and count
        n = acc_q.size(); m = first_q.size();
        stim_q.push_back(mk(1, 2, 3, 4, 5, 6, 7, 0));
        wait_acc(n + 1, 50);
        wait_first(m + 1, 50);
        if (first_q.size() > m && acc_q.size() > n)
            check("t1_latency", first_q[m] - acc_q[n], 1);
        wait_idle(200);
        check("t1_frames_sent", 32'(frames_sent), 1);
        check("t1_busy", 32'(busy), 0);

        // 2: back-to-back, B buffered during A's burst
        n = acc_q.size(); m = first_q.size(); r = rise_q.size();
        stim_q.push_back(mk(7, 6, 5, 4, 3, 2, 1, 0));
        stim_q.push_back(mk(0, 1, 0, 1, 6, 6, 6, 6));
        wait_acc(n + 2, 50);
        check("t2_ready_low", 32'(bus.frm_ready), 0);
        check("t2_busy", 32'(busy), 1);
        if (acc_q.size() >= n + 2) check("t2_b_accept", acc_q[n+1] - acc_q[n], 1);
        wait_first(m + 2, 100);
        if (first_q.size() >= m + 2) begin
            check("t2_spacing", first_q[m+1] - first_q[m], TAPS + GAP);
            check("t2_ready_rise", (rise_q.size() > r) ? rise_q[r] : -1, first_q[m+1] - 1);
        end
        wait_idle(200);

        // 3: frame accepted on the final gap edge with the buffer empty
        n = acc_q.size(); m = first_q.size();
        stim_q.push_back(mk(2, 4, 6, 1, 3, 5, 7, 2));
        wait_first(m + 1, 50);
        f = (first_q.size() > m) ? first_q[m] : cyc;
        wait_cyc(f + TAPS + GAP - 3);
        stim_q.push_back(mk(5, 5, 3, 3, 1, 1, 4, 4));
        wait_acc(n + 2, 50);
        if (acc_q.size() >= n + 2) check("t3_accept_edge", acc_q[n+1], f + TAPS + GAP - 1);
        wait_first(m + 2, 50);
        if (first_q.size() >= m + 2) check("t3_spacing", first_q[m+1] - first_q[m], TAPS + GAP);
        wait_idle(200);

        // 4: third frame held off while the buffer is full
        n = acc_q.size(); m = first_q.size();
        stim_q.push_back(mk(1, 1, 1, 1, 2, 2, 2, 2));
        stim_q.push_back(mk(3, 3, 3, 3, 4, 4, 4, 4));
        stim_q.push_back(mk(5, 6, 7, 1, 7, 6, 5, 3));
        wait_acc(n + 2, 50);
        repeat (5) begin @(posedge clk_1); #2; end
        check("t4_ready_low", 32'(bus.frm_ready), 0);
        check("t4_valid_held", 32'(bus.frm_valid), 1);
        wait_acc(n + 3, 100);
        wait_first(m + 2, 100);
        if (acc_q.size() >= n + 3 && first_q.size() >= m + 2)
            check("t4_third_accept", acc_q[n+2], first_q[m+1]);
        wait_idle(300);

        // 5: reset during beat 2 with a frame buffered
        n = acc_q.size();
        stim_q.push_back(mk(6, 5, 4, 3, 1, 2, 3, 4));
        stim_q.push_back(mk(7, 7, 7, 7, 7, 7, 7, 7));
        wait_acc(n + 1, 50);
        e = (acc_q.size() > n) ? acc_q[n] : cyc;
        wait_cyc(e + 3);
        rst_n = 1'b0;
        #1;
        check("t5_in_valid", 32'(bus.in_valid), 0);
        check("t5_in_data", 32'({bus.in_data1, bus.in_data2}), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_frames_sent", 32'(frames_sent), 0);
        check("t5_frm_ready", 32'(bus.frm_ready), 1);
        repeat (3) @(posedge clk_1);
        @(negedge clk_1);
        rst_n = 1'b1;
        repeat (30) begin @(posedge clk_1); #2; end
        check("t5_quiet_busy", 32'(busy), 0);
        stim_q.push_back(mk(4, 3, 2, 1, 0, 7, 6, 5));
        wait_idle(200);
        check("t5_resend_count", 32'(frames_sent), 1);

        // 6: 256 frames back-to-back, counter wraps to 0
        rst_n = 1'b0;
        repeat (2) @(posedge clk_1);
        @(negedge clk_1);
        rst_n = 1'b1;
        m = first_q.size();
        for (int i = 0; i < 256; i++) begin
            fr.h = '0;
            fr.x = '0;
            for (int k = 0; k < TAPS; k++) begin
                fr.h = conv_pack_elem(fr.h, k, 3'(i + k));
                fr.x = conv_pack_elem(fr.x, k, 3'((i >> 3) + 5 * k));
            end
            stim_q.push_back(fr);
        end
        wait_idle(8000);
        check("t6_frames_wrap", 32'(frames_sent), 0);
        check("t6_burst_count", first_q.size() - m, 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
